// File: rtl/matrix_keypad_scanner.sv
// Column-scanned keypad reader: drives one column low at a time, debounces whole-scan
// results and hands out one key code per press. Define KEYPAD_REPEAT_EN for auto-repeat.
module matrix_keypad_scanner #(
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 200,
  localparam int CODE_W        = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              r,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_held,
  output logic              multi_key,
  output logic              overrun
);
  localparam int KEYS   = ROWS*COLS;
  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS+1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [SLOT_W-1:0] slot_cnt;
  logic [COL_W-1:0]  col_idx;
  logic [ROWS-1:0]   row_meta, row_sync;
  logic [KEYS-1:0]   scan_map, cur_map;
  logic [1:0]        hits;
  logic [CODE_W-1:0] hit_code;
  logic              sample, scan_end, single, cand_closed, emit;

  state_t            state, state_n;
  logic [CODE_W-1:0] cand, cand_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS+1);
  logic [REP_W-1:0]  rep, rep_n;
`endif

  assign sample   = (slot_cnt == SLOT_W'(SCAN_DIV-1));
  assign scan_end = sample && (col_idx == COL_W'(COLS-1));
  assign key_held = (state == PRESSED) || (state == RELEASE);

  always_comb begin
    col_n          = '1;
    col_n[col_idx] = 1'b0;
  end

  // Map of closed keys seen so far this scan, including the column sampled now
  always_comb begin
    cur_map = scan_map;
    for (int i = 0; i < ROWS; i++)
      if (!row_sync[i]) cur_map[i*COLS + int'(col_idx)] = 1'b1;
  end

  always_comb begin
    hits     = 2'd0;
    hit_code = '0;
    for (int k = 0; k < KEYS; k++)
      if (cur_map[k]) begin
        if (hits != 2'd2) hits = hits + 2'd1;
        hit_code = CODE_W'(k);
      end
  end

  assign single      = (hits == 2'd1);
  assign cand_closed = cur_map[cand];

  always_ff @(posedge clk) begin
    if (r) begin
      slot_cnt  <= '0;
      col_idx   <= '0;
      row_meta  <= '1;
      row_sync  <= '1;
      scan_map  <= '0;
      multi_key <= 1'b0;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
      if (sample) begin
        slot_cnt <= '0;
        if (scan_end) begin
          col_idx   <= '0;
          scan_map  <= '0;
          multi_key <= (hits == 2'd2);
        end else begin
          col_idx  <= col_idx + 1'b1;
          scan_map <= cur_map;
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep   <= '0;
`endif
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
`ifdef KEYPAD_REPEAT_EN
      rep   <= rep_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_n   = rep;
`endif
    if (scan_end) begin
      case (state)
        IDLE:
          if (single) begin
            state_n = DEBOUNCE;
            cand_n  = hit_code;
            cnt_n   = CNT_W'(1);
          end
        DEBOUNCE:
          if (single && hit_code == cand) begin
            if (cnt == CNT_W'(DEBOUNCE_SCANS-1)) begin
              state_n = PRESSED;
              emit    = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_n   = '0;
`endif
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = IDLE;
          end
        PRESSED:
          if (!cand_closed) begin
            state_n = RELEASE;
            cnt_n   = CNT_W'(1);
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep == REP_W'(REPEAT_SCANS-1)) begin
            emit  = 1'b1;
            rep_n = '0;
          end else begin
            rep_n = rep + 1'b1;
          end
`endif
        RELEASE:
          if (cand_closed) begin
            state_n = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_n   = '0;
`endif
          end else if (cnt == CNT_W'(DEBOUNCE_SCANS-1)) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        default: state_n = IDLE;
      endcase
    end
  end

  // An ack in the same cycle frees the slot, so a simultaneous emit is not an overrun
  always_ff @(posedge clk) begin
    if (r) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (emit && (!key_valid || key_ack)) begin
      key_code  <= cand;
      key_valid <= 1'b1;
    end else if (emit) begin
      overrun   <= 1'b1;
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner: keypad model, event scoreboard with auto-ack
// monitor, and direct checks of timing, debounce, multi-key and overrun behaviour.
module tb_matrix_keypad_scanner;
  localparam int COLS = 4, ROWS = 4, SCAN = 16;
`ifdef KEYPAD_REPEAT_EN
  localparam int NREP = 3;
`else
  localparam int NREP = 1;
`endif

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic [3:0] row_n, col_n, key_code;
  logic       key_valid, key_held, multi_key, overrun;
  logic       key_ack = 1'b0;
  logic [15:0] keys = '0;

  int n_cmp = 0, n_bad = 0;
  int n_events = 0, valid_cycles = 0, held_cycles = 0;
  bit auto_ack = 1'b0;
  int exp_q[$];

  matrix_keypad_scanner #(.COLS(COLS), .ROWS(ROWS), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
                          .REPEAT_SCANS(8)) dut (
    .clk(clk), .r(r), .row_n(row_n), .col_n(col_n), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held),
    .multi_key(multi_key), .overrun(overrun));

  always #5 clk = ~clk;

  // Passive keypad: a closed key pulls its row low while its column is driven
  always_comb begin
    row_n = '1;
    for (int i = 0; i < ROWS; i++)
      for (int c = 0; c < COLS; c++)
        if (keys[i*COLS + c] && !col_n[c]) row_n[i] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (key_valid) valid_cycles++;
    if (key_held) held_cycles++;
    if (key_valid && auto_ack && !key_ack) begin
      n_events++;
      if (exp_q.size() == 0) check("unexpected_event", int'(key_code), -1);
      else check("event_code", int'(key_code), exp_q.pop_front());
      key_ack = 1'b1;
    end else begin
      key_ack = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d checks done", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, h0, e0;
    // 1: reset state and column walk
    tick(2);
    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);
    check("rst_multi", int'(multi_key), 0);
    check("rst_overrun", int'(overrun), 0);
    r = 1'b0;
    tick(4); check("col_step1", int'(col_n), 4'b1101);
    tick(4); check("col_step2", int'(col_n), 4'b1011);
    tick(4); check("col_step3", int'(col_n), 4'b0111);
    tick(4); check("col_wrap", int'(col_n), 4'b1110);

    // 2: key 6 held for 6 scans, acked
    auto_ack = 1'b1;
    e0 = n_events;
    exp_q.push_back(6);
    keys = 16'h0040;
    tick(3*SCAN - 1); check("t2_not_yet_valid", int'(key_valid), 0);
    tick(1);          check("t2_valid", int'(key_valid), 1);
    check("t2_code", int'(key_code), 6);
    tick(1);          check("t2_valid_drop", int'(key_valid), 0);
    check("t2_held", int'(key_held), 1);
    tick(6*SCAN - 3*SCAN - 1);
    keys = '0;
    tick(4*SCAN);
    check("t2_held_off", int'(key_held), 0);
    check("t2_events", n_events - e0, 1);

    // 3: bouncing key 9 never accepted
    v0 = valid_cycles; h0 = held_cycles;
    keys = 16'h0200; tick(2*SCAN);
    keys = '0;       tick(SCAN);
    keys = 16'h0200; tick(2*SCAN);
    keys = '0;       tick(4*SCAN);
    check("t3_valid_cycles", valid_cycles - v0, 0);
    check("t3_held_cycles", held_cycles - h0, 0);

    // 4: keys 0 and 5 together
    v0 = valid_cycles; h0 = held_cycles;
    keys = 16'h0021;
    tick(SCAN - 1); check("t4_multi_before", int'(multi_key), 0);
    tick(1);        check("t4_multi_first", int'(multi_key), 1);
    tick(4*SCAN);   check("t4_multi_hold", int'(multi_key), 1);
    check("t4_no_event", valid_cycles - v0, 0);
    check("t4_no_held", held_cycles - h0, 0);
    keys = '0;
    tick(SCAN);     check("t4_multi_clear", int'(multi_key), 0);

    // 5: unacked key 3, then key 12 is dropped
    auto_ack = 1'b0;
    keys = 16'h0008; tick(4*SCAN);
    check("t5_valid", int'(key_valid), 1);
    check("t5_code", int'(key_code), 3);
    check("t5_no_overrun", int'(overrun), 0);
    keys = '0;       tick(4*SCAN);
    keys = 16'h1000; tick(4*SCAN);
    check("t5_code_kept", int'(key_code), 3);
    check("t5_valid_kept", int'(key_valid), 1);
    check("t5_overrun", int'(overrun), 1);
    keys = '0;       tick(4*SCAN);
    check("t5_overrun_sticky", int'(overrun), 1);
    r = 1'b1; tick(2); r = 1'b0;
    check("t5_rst_overrun", int'(overrun), 0);
    check("t5_rst_valid", int'(key_valid), 0);
    check("t5_rst_col", int'(col_n), 4'b1110);

    // 6: key 7 held 20 scans, auto-repeat when enabled
    auto_ack = 1'b1;
    e0 = n_events;
    for (int i = 0; i < NREP; i++) exp_q.push_back(7);
    keys = 16'h0080; tick(20*SCAN);
    keys = '0;       tick(4*SCAN);
    check("t6_events", n_events - e0, NREP);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
